// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: ALU codes, opcodes, mux selects, states.
package mc_ctrl_pkg;

    localparam logic [2:0] ALU_NOP  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;

    localparam logic [1:0] RDST_RT = 2'b00, RDST_RD = 2'b01, RDST_RA = 2'b10;
    localparam logic [1:0] WB_ALU  = 2'b00, WB_MDR  = 2'b01, WB_PC   = 2'b10;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_REG = 2'b01, SRCA_SHAMT = 2'b10;
    localparam logic [1:0] SRCB_REG = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_BR = 2'b11;
    localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE, S_EXE_R, S_ALUWB_R, S_EXE_I, S_ALUWB_I, S_MEMADR,
        S_MEMRD, S_MEMWR, S_MEMWB, S_BRANCH, S_JUMP, S_JAL, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        IT_R, IT_LW, IT_SW, IT_BEQ, IT_ADDI, IT_ORI, IT_J, IT_JAL, IT_ILL
    } itype_t;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       ext_op;
        logic [1:0] pc_source;
        logic       illegal;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational Op/Funct decode into instruction class, ALU code, extend mode and legality.
// MC_CTRL_JAL_EN: when defined, Op 000011 decodes as jal; otherwise it is illegal.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] itype_o,
    output logic [2:0] alu_op_o,
    output logic       ext_op_o,
    output logic       legal_o
);

    itype_t itype;

    always_comb begin
        itype    = IT_ILL;
        alu_op_o = ALU_ADD;
        ext_op_o = 1'b1;
        legal_o  = 1'b1;
        case (op_i)
            OP_R: begin
                itype = IT_R;
                case (funct_i)
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    FN_SLTU: alu_op_o = ALU_SLTU;
                    FN_SLL:  alu_op_o = ALU_SLL;
                    default: begin
                        alu_op_o = ALU_NOP;
                        legal_o  = 1'b0;
                    end
                endcase
            end
            OP_LW:   itype = IT_LW;
            OP_SW:   itype = IT_SW;
            OP_BEQ: begin
                itype    = IT_BEQ;
                alu_op_o = ALU_SUB;
            end
            OP_ADDI: itype = IT_ADDI;
            OP_ORI: begin
                itype    = IT_ORI;
                alu_op_o = ALU_OR;
                ext_op_o = 1'b0;
            end
            OP_J:    itype = IT_J;
`ifdef MC_CTRL_JAL_EN
            OP_JAL:  itype = IT_JAL;
`endif
            default: legal_o = 1'b0;
        endcase
    end

    assign itype_o = itype;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM; outputs are decoded from state, Op and Funct.
// ILLEGAL_TRAP selects HALT (1) or silent return to FETCH (0) for unsupported instructions.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       IorD,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       EXTOp,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic       halted
);

    localparam state_t TRAP_DEST = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;

    state_t     state_q, state_d;
    logic [3:0] dec_itype_raw;
    itype_t     dec_itype;
    logic [2:0] dec_alu_op;
    logic       dec_ext_op;
    logic       dec_legal;
    ctrl_t      ctrl_d, ctrl;

    mc_ctrl_decode u_decode (
        .op_i     (Op),
        .funct_i  (Funct),
        .itype_o  (dec_itype_raw),
        .alu_op_o (dec_alu_op),
        .ext_op_o (dec_ext_op),
        .legal_o  (dec_legal)
    );

    assign dec_itype = itype_t'(dec_itype_raw);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (dec_itype)
                    IT_R:           state_d = S_EXE_R;
                    IT_LW, IT_SW:   state_d = S_MEMADR;
                    IT_BEQ:         state_d = S_BRANCH;
                    IT_ADDI, IT_ORI: state_d = S_EXE_I;
                    IT_J:           state_d = S_JUMP;
                    IT_JAL:         state_d = S_JAL;
                    default:        state_d = TRAP_DEST;
                endcase
            end
            S_EXE_R:  state_d = dec_legal ? S_ALUWB_R : TRAP_DEST;
            S_EXE_I:  state_d = S_ALUWB_I;
            S_MEMADR: state_d = (dec_itype == IT_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        ctrl_d = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.alu_src_a = SRCA_PC;
                ctrl_d.alu_src_b = SRCB_4;
                ctrl_d.alu_op    = ALU_ADD;
                ctrl_d.pc_source = PCS_ALU;
                ctrl_d.ir_write  = mem_ready;
                ctrl_d.pc_en     = mem_ready;
            end
            S_DECODE: begin
                ctrl_d.alu_src_a = SRCA_PC;
                ctrl_d.alu_src_b = SRCB_BR;
                ctrl_d.ext_op    = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
                ctrl_d.illegal   = (dec_itype == IT_ILL);
            end
            S_EXE_R: begin
                ctrl_d.alu_src_a = (Funct == FN_SLL) ? SRCA_SHAMT : SRCA_REG;
                ctrl_d.alu_src_b = SRCB_REG;
                ctrl_d.alu_op    = dec_alu_op;
                ctrl_d.illegal   = !dec_legal;
            end
            S_ALUWB_R: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dst    = RDST_RD;
                ctrl_d.mem_to_reg = WB_ALU;
            end
            S_EXE_I: begin
                ctrl_d.alu_src_a = SRCA_REG;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.alu_op    = dec_alu_op;
                ctrl_d.ext_op    = dec_ext_op;
            end
            S_ALUWB_I: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dst    = RDST_RT;
                ctrl_d.mem_to_reg = WB_ALU;
            end
            S_MEMADR: begin
                ctrl_d.alu_src_a = SRCA_REG;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.ext_op    = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_d.mem_req = 1'b1;
                ctrl_d.iord    = 1'b1;
            end
            S_MEMWR: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.iord      = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            S_MEMWB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dst    = RDST_RT;
                ctrl_d.mem_to_reg = WB_MDR;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a = SRCA_REG;
                ctrl_d.alu_src_b = SRCB_REG;
                ctrl_d.alu_op    = ALU_SUB;
                ctrl_d.pc_source = PCS_ALUOUT;
                ctrl_d.pc_en     = Zero;
            end
            S_JUMP: begin
                ctrl_d.pc_source = PCS_JUMP;
                ctrl_d.pc_en     = 1'b1;
            end
            // PC already holds PC+4 from FETCH, so it is the link value.
            S_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dst    = RDST_RA;
                ctrl_d.mem_to_reg = WB_PC;
                ctrl_d.pc_source  = PCS_JUMP;
                ctrl_d.pc_en      = 1'b1;
            end
            S_HALT:  ctrl_d.halted = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // Reset masks every output immediately, abandoning any in-flight access.
    assign ctrl = rst ? '0 : ctrl_d;

    assign pc_en    = ctrl.pc_en;
    assign IorD     = ctrl.iord;
    assign mem_req  = ctrl.mem_req;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign RegWrite = ctrl.reg_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign EXTOp    = ctrl.ext_op;
    assign PCSource = ctrl.pc_source;
    assign illegal  = ctrl.illegal;
    assign halted   = ctrl.halted;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: two instances (trap to HALT / trap to FETCH) share stimulus; per-cycle scoreboard.
`timescale 1ns/1ps
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    wire [21:0] out1;
    wire [21:0] out0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        z;
        logic [21:0] e1;
        logic [21:0] e0;
    } ent_t;
    ent_t sb[$];

    always #5 clk = ~clk;

    mc_ctrl #(.ILLEGAL_TRAP(1)) dut1 (
        .clk(clk), .rst(rst), .Op(op), .Funct(funct), .Zero(zero), .mem_ready(mem_ready),
        .pc_en(out1[21]), .IorD(out1[20]), .mem_req(out1[19]), .MemWrite(out1[18]),
        .IRWrite(out1[17]), .RegWrite(out1[16]), .RegDst(out1[15:14]), .MemtoReg(out1[13:12]),
        .ALUSrcA(out1[11:10]), .ALUSrcB(out1[9:8]), .ALUOp(out1[7:5]), .EXTOp(out1[4]),
        .PCSource(out1[3:2]), .illegal(out1[1]), .halted(out1[0])
    );

    mc_ctrl #(.ILLEGAL_TRAP(0)) dut0 (
        .clk(clk), .rst(rst), .Op(op), .Funct(funct), .Zero(zero), .mem_ready(mem_ready),
        .pc_en(out0[21]), .IorD(out0[20]), .mem_req(out0[19]), .MemWrite(out0[18]),
        .IRWrite(out0[17]), .RegWrite(out0[16]), .RegDst(out0[15:14]), .MemtoReg(out0[13:12]),
        .ALUSrcA(out0[11:10]), .ALUSrcB(out0[9:8]), .ALUOp(out0[7:5]), .EXTOp(out0[4]),
        .PCSource(out0[3:2]), .illegal(out0[1]), .halted(out0[0])
    );

    function automatic logic [21:0] ov(input logic pce, iord, req, mw, irw, rw,
                                       input logic [1:0] rdst, m2r, sa, sb_,
                                       input logic [2:0] aop, input logic ext,
                                       input logic [1:0] pcs, input logic ill, hlt);
        return {pce, iord, req, mw, irw, rw, rdst, m2r, sa, sb_, aop, ext, pcs, ill, hlt};
    endfunction

    task automatic chk(input string tag, input logic [21:0] act, input logic [21:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic rdy, input logic z,
                        input logic [21:0] e1, input logic [21:0] e0);
        ent_t e;
        e.rst = r; e.rdy = rdy; e.z = z; e.e1 = e1; e.e0 = e0;
        sb.push_back(e);
    endtask

    task automatic push2(input logic r, input logic rdy, input logic z, input logic [21:0] e);
        push(r, rdy, z, e, e);
    endtask

    task automatic run(input string name, input logic [5:0] o, input logic [5:0] f);
        ent_t e;
        int   idx = 0;
        op    = o;
        funct = f;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst       = e.rst;
            mem_ready = e.rdy;
            zero      = e.z;
            #1;
            chk($sformatf("%s.c%0d.trap1", name, idx), out1, e.e1);
            chk($sformatf("%s.c%0d.trap0", name, idx), out0, e.e0);
            idx++;
        end
    endtask

    logic [21:0] E_ZERO, E_FW, E_FG, E_DEC, E_DEC_ILL, E_WBR, E_EXI_ADDI, E_EXI_ORI, E_WBI;
    logic [21:0] E_MA, E_MRD, E_MWR, E_MWB, E_J, E_JAL, E_HALT, E_EXR_BAD;

    logic [5:0] fn_tab [0:6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b101010, 6'b101011, 6'b000000};
    logic [2:0] aop_tab[0:6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [1:0] sa_tab [0:6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    initial begin
        E_ZERO     = '0;
        E_FW       = ov(0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b001,0, 2'b00,0,0);
        E_FG       = ov(1,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b001,0, 2'b00,0,0);
        E_DEC      = ov(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11, 3'b001,1, 2'b00,0,0);
        E_DEC_ILL  = ov(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11, 3'b001,1, 2'b00,1,0);
        E_WBR      = ov(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 3'b000,0, 2'b00,0,0);
        E_EXI_ADDI = ov(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b10, 3'b001,1, 2'b00,0,0);
        E_EXI_ORI  = ov(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b10, 3'b100,0, 2'b00,0,0);
        E_WBI      = ov(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000,0, 2'b00,0,0);
        E_MA       = ov(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b10, 3'b001,1, 2'b00,0,0);
        E_MRD      = ov(0,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0, 2'b00,0,0);
        E_MWR      = ov(0,1,1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0, 2'b00,0,0);
        E_MWB      = ov(0,0,0,0,0,1, 2'b00,2'b01,2'b00,2'b00, 3'b000,0, 2'b00,0,0);
        E_J        = ov(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0, 2'b10,0,0);
        E_JAL      = ov(1,0,0,0,0,1, 2'b10,2'b10,2'b00,2'b00, 3'b000,0, 2'b10,0,0);
        E_HALT     = ov(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0, 2'b00,0,1);
        E_EXR_BAD  = ov(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 3'b000,0, 2'b00,1,0);

        // reset held, then a pulse mid-FETCH while memory is stalled/ready
        push2(1, 0, 0, E_ZERO);
        push2(1, 1, 0, E_ZERO);
        push2(0, 0, 0, E_FW);
        push2(0, 0, 0, E_FW);
        push2(1, 1, 0, E_ZERO);
        push2(0, 0, 0, E_FW);
        run("reset", 6'b000000, 6'b100000);

        for (int i = 0; i < 7; i++) begin
            push2(0, 1, 0, E_FG);
            push2(0, 1, 0, E_DEC);
            push2(0, 1, 0, ov(0,0,0,0,0,0, 2'b00,2'b00,sa_tab[i],2'b00, aop_tab[i],0, 2'b00,0,0));
            push2(0, 1, 0, E_WBR);
            run($sformatf("rtype%0d", i), 6'b000000, fn_tab[i]);
        end

        push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC); push2(0, 1, 0, E_EXI_ADDI); push2(0, 1, 0, E_WBI);
        run("addi", 6'b001000, 6'b010101);
        push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC); push2(0, 1, 0, E_EXI_ORI); push2(0, 1, 0, E_WBI);
        run("ori", 6'b001101, 6'b000000);

        push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC); push2(0, 1, 0, E_MA);
        for (int i = 0; i < 3; i++) push2(0, 0, 0, E_MRD);
        push2(0, 1, 0, E_MRD); push2(0, 1, 0, E_MWB);
        run("lw_wait3", 6'b100011, 6'b000000);

        push2(0, 0, 0, E_FW); push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC); push2(0, 1, 0, E_MA);
        push2(0, 1, 0, E_MWR);
        run("sw", 6'b101011, 6'b000000);

        push2(0, 1, 1, E_FG); push2(0, 1, 1, E_DEC);
        push2(0, 1, 1, ov(1,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 3'b010,0, 2'b01,0,0));
        run("beq_taken", 6'b000100, 6'b000000);
        push2(0, 1, 1, E_FG); push2(0, 1, 1, E_DEC);
        push2(0, 1, 0, ov(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 3'b010,0, 2'b01,0,0));
        run("beq_not", 6'b000100, 6'b000000);

        push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC); push2(0, 1, 0, E_J);
        run("j", 6'b000010, 6'b000000);

`ifdef MC_CTRL_JAL_EN
        push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC); push2(0, 1, 0, E_JAL);
        run("jal", 6'b000011, 6'b000000);
`else
        push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC_ILL);
        push(0, 0, 0, E_HALT, E_FW);
        push2(1, 0, 0, E_ZERO);
        push2(0, 0, 0, E_FW);
        run("jal_off", 6'b000011, 6'b000000);
`endif

        // unknown Op: single illegal pulse per decode, HALT absorbing until reset
        push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC_ILL);
        push(0, 0, 0, E_HALT, E_FW);
        push(0, 1, 0, E_HALT, E_FG);
        push(0, 0, 0, E_HALT, E_DEC_ILL);
        push(0, 0, 0, E_HALT, E_FW);
        push2(1, 0, 0, E_ZERO);
        push2(0, 0, 0, E_FW);
        run("bad_op", 6'b111111, 6'b000000);

        push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC); push2(0, 1, 0, E_EXR_BAD);
        push(0, 0, 0, E_HALT, E_FW);
        push2(1, 0, 0, E_ZERO);
        push2(0, 0, 0, E_FW);
        run("bad_funct", 6'b000000, 6'b111111);

        // reset mid-read abandons the access; next instruction starts clean
        push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC); push2(0, 1, 0, E_MA); push2(0, 0, 0, E_MRD);
        push2(1, 1, 0, E_ZERO);
        push2(0, 0, 0, E_FW);
        run("rst_memrd", 6'b100011, 6'b000000);

        push2(0, 1, 0, E_FG); push2(0, 1, 0, E_DEC); push2(0, 1, 0, E_EXI_ADDI); push2(0, 1, 0, E_WBI);
        push2(0, 0, 0, E_FW);
        run("addi_after", 6'b001000, 6'b000000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
